// File: rtl/ttt_pkg.sv
// Shared types, constants and board helpers for the tic-tac-toe engine.
// Squares are numbered 0..8 row-major; bit i of a board is square i.
package ttt_pkg;

  typedef enum logic [2:0] {
    WAIT_HUMAN,
    CHECK_X,
    CPU_MOVE,
    CHECK_O,
    GAME_OVER
  } state_e;

  localparam logic [1:0] ST_PLAYING = 2'b00;
  localparam logic [1:0] ST_X_WON   = 2'b01;
  localparam logic [1:0] ST_O_WON   = 2'b10;
  localparam logic [1:0] ST_DRAW    = 2'b11;

  localparam logic [8:0] FULL_BOARD = 9'h1FF;
  localparam logic [8:0] CENTER     = 9'h010;
  localparam logic [8:0] CORNERS    = 9'h145;
  localparam logic [8:0] SIDES      = 9'h0AA;

  // Index 0..2 rows, 3..5 columns, 6..7 diagonals.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h054, 9'h111,
    9'h124, 9'h092, 9'h049,
    9'h1C0, 9'h038, 9'h007
  };

  function automatic logic three_in_line(input logic [8:0] board);
    logic found;
    found = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((board & WIN_LINES[l]) == WIN_LINES[l]) found = 1'b1;
    end
    return found;
  endfunction

  // Returns 0 for an empty mask; callers only use it on non-empty masks.
  function automatic logic [3:0] lowest_bit(input logic [8:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ttt_cpu_player_if.sv
// Human-move handshake between the user-input front end (master) and the engine (slave).
interface ttt_cpu_player_if;
  logic       mv_valid;
  logic [3:0] mv_pos;
  logic       mv_ready;
  logic       mv_err;

  modport master (output mv_valid, output mv_pos, input mv_ready, input mv_err);
  modport slave  (input mv_valid, input mv_pos, output mv_ready, output mv_err);
endinterface

// File: rtl/ttt_cpu_player_two_in_array.sv
// Two-in-a-row detector: marks every empty square that would complete a
// line already holding two of the pieces in a_i. Squares held by either
// side are never reported.
module TwoInArray
  import ttt_pkg::*;
(
  input  logic [8:0] a_i,
  input  logic [8:0] b_i,
  output logic [8:0] hit_o
);

  // Scan all eight lines and collect the third square of each open pair.
  always_comb begin
    hit_o = '0;
    for (int l = 0; l < 8; l++) begin
      if ($countones(a_i & WIN_LINES[l]) == 2) begin
        hit_o = hit_o | (WIN_LINES[l] & ~a_i & ~b_i);
      end
    end
  end

endmodule

// File: rtl/ttt_cpu_player.sv
// Tic-tac-toe engine: owns both boards, takes X moves from the front end,
// answers with an O move (win, block, centre, corner, side) and tracks the
// game result.
module ttt_cpu_player
  import ttt_pkg::*;
#(
  parameter bit CPU_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                new_game,
  ttt_cpu_player_if.slave     mv,
  output logic [8:0]          xs,
  output logic [8:0]          os,
  output logic                cpu_valid,
  output logic [3:0]          cpu_pos,
  output logic [1:0]          status
);

  state_e     state_q, state_d;
  logic [8:0] xs_q, xs_d;
  logic [8:0] os_q, os_d;
  logic [1:0] status_q, status_d;
  logic [3:0] cpuPos_q, cpuPos_d;
  logic       cpuValid_q, cpuValid_d;
  logic       mvErr_q, mvErr_d;
  logic       startPending_q;

  logic [8:0]  occupied;
  logic [8:0]  winMask;
  logic [8:0]  blockMask;
  logic [3:0]  pickPos;
  logic [8:0]  pickOneHot;
  logic [15:0] humanOneHot;
  logic        humanIllegal;

  assign occupied     = xs_q | os_q;
  assign humanOneHot  = 16'(1) << mv.mv_pos;
  assign humanIllegal = (mv.mv_pos > 4'd8) || ((humanOneHot[8:0] & occupied) != 9'h000);
  assign pickOneHot   = 9'(1) << pickPos;

  TwoInArray u_win (
    .a_i   (os_q),
    .b_i   (xs_q),
    .hit_o (winMask)
  );

  TwoInArray u_block (
    .a_i   (xs_q),
    .b_i   (os_q),
    .hit_o (blockMask)
  );

  // Computer move choice: first non-empty preference mask, lowest square within it.
  always_comb begin
    pickPos = 4'd0;
    if (winMask != 9'h000) begin
      pickPos = lowest_bit(winMask);
    end else if (blockMask != 9'h000) begin
      pickPos = lowest_bit(blockMask);
    end else if ((CENTER & ~occupied) != 9'h000) begin
      pickPos = 4'd4;
    end else if ((CORNERS & ~occupied) != 9'h000) begin
      pickPos = lowest_bit(CORNERS & ~occupied);
    end else begin
      pickPos = lowest_bit(SIDES & ~occupied);
    end
  end

  // Game flow; a restart (explicit or the first edge out of reset) overrides every state.
  always_comb begin
    state_d    = state_q;
    xs_d       = xs_q;
    os_d       = os_q;
    status_d   = status_q;
    cpuPos_d   = cpuPos_q;
    cpuValid_d = 1'b0;
    mvErr_d    = 1'b0;
    if (new_game || startPending_q) begin
      xs_d     = '0;
      os_d     = '0;
      status_d = ST_PLAYING;
      state_d  = CPU_FIRST ? CPU_MOVE : WAIT_HUMAN;
    end else begin
      case (state_q)
        WAIT_HUMAN: begin
          if (mv.mv_valid) begin
            if (humanIllegal) begin
              mvErr_d = 1'b1;
            end else begin
              xs_d    = xs_q | humanOneHot[8:0];
              state_d = CHECK_X;
            end
          end
        end
        CHECK_X: begin
          if (three_in_line(xs_q)) begin
            status_d = ST_X_WON;
            state_d  = GAME_OVER;
          end else if (occupied == FULL_BOARD) begin
            status_d = ST_DRAW;
            state_d  = GAME_OVER;
          end else begin
            state_d = CPU_MOVE;
          end
        end
        CPU_MOVE: begin
          os_d       = os_q | pickOneHot;
          cpuPos_d   = pickPos;
          cpuValid_d = 1'b1;
          state_d    = CHECK_O;
        end
        CHECK_O: begin
          if (three_in_line(os_q)) begin
            status_d = ST_O_WON;
            state_d  = GAME_OVER;
          end else if (occupied == FULL_BOARD) begin
            status_d = ST_DRAW;
            state_d  = GAME_OVER;
          end else begin
            state_d = WAIT_HUMAN;
          end
        end
        GAME_OVER: begin
          state_d = GAME_OVER;
        end
        default: begin
          state_d = GAME_OVER;
        end
      endcase
    end
  end

  // State and board registers; reset parks in GAME_OVER with a restart pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= GAME_OVER;
      xs_q           <= '0;
      os_q           <= '0;
      status_q       <= ST_PLAYING;
      cpuPos_q       <= '0;
      cpuValid_q     <= 1'b0;
      mvErr_q        <= 1'b0;
      startPending_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      xs_q           <= xs_d;
      os_q           <= os_d;
      status_q       <= status_d;
      cpuPos_q       <= cpuPos_d;
      cpuValid_q     <= cpuValid_d;
      mvErr_q        <= mvErr_d;
      startPending_q <= 1'b0;
    end
  end

  assign mv.mv_ready = (state_q == WAIT_HUMAN) && !startPending_q;
  assign mv.mv_err   = mvErr_q;
  assign xs          = xs_q;
  assign os          = os_q;
  assign cpu_valid   = cpuValid_q;
  assign cpu_pos     = cpuPos_q;
  assign status      = status_q;

endmodule

// File: tb/tb_ttt_cpu_player.sv
// Directed bench for ttt_cpu_player: scripted games from a vector table plus
// hand-written sequences for restart, reset and ignored-move corner cases.
module tb_ttt_cpu_player;

  typedef struct {
    logic       newGame;
    logic [3:0] pos;
    logic       expErr;
    logic       expCpu;
    logic [3:0] expCpuPos;
    logic [1:0] expStatus;
    logic [8:0] expXs;
    logic [8:0] expOs;
  } moveVec_t;

  localparam int NUM_VECS = 17;

  logic       clk;
  logic       rst_n;
  logic       newGame;
  logic       newGame2;
  logic [8:0] xs, os, xs2, os2;
  logic       cpuValid, cpuValid2;
  logic [3:0] cpuPos, cpuPos2;
  logic [1:0] status, status2;

  int vectorsApplied = 0;
  int miscompares    = 0;

  moveVec_t vecs [NUM_VECS];

  ttt_cpu_player_if mvIf ();
  ttt_cpu_player_if mvIf2 ();

  ttt_cpu_player #(.CPU_FIRST(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_game  (newGame),
    .mv        (mvIf.slave),
    .xs        (xs),
    .os        (os),
    .cpu_valid (cpuValid),
    .cpu_pos   (cpuPos),
    .status    (status)
  );

  ttt_cpu_player #(.CPU_FIRST(1'b1)) dutCpuFirst (
    .clk       (clk),
    .rst_n     (rst_n),
    .new_game  (newGame2),
    .mv        (mvIf2.slave),
    .xs        (xs2),
    .os        (os2),
    .cpu_valid (cpuValid2),
    .cpu_pos   (cpuPos2),
    .status    (status2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic startNewGame();
    newGame = 1'b1;
    @(posedge clk); #1;
    newGame = 1'b0;
    checkOutput("ngXs", xs, 9'h000);
    checkOutput("ngOs", os, 9'h000);
    checkOutput("ngStatus", 9'(status), 9'h000);
    checkOutput("ngReady", 9'(mvIf.mv_ready), 9'h001);
  endtask

  task automatic applyStimulus(input moveVec_t v);
    int   waitCycles;
    logic expReady;
    if (v.newGame) startNewGame();
    waitCycles = 0;
    while (mvIf.mv_ready !== 1'b1 && waitCycles < 8) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (mvIf.mv_ready !== 1'b1) begin
      checkOutput("readyTimeout", 9'(mvIf.mv_ready), 9'h001);
      return;
    end
    mvIf.mv_valid = 1'b1;
    mvIf.mv_pos   = v.pos;
    @(posedge clk); #1;
    mvIf.mv_valid = 1'b0;
    if (v.expErr) begin
      checkOutput("errPulse", 9'(mvIf.mv_err), 9'h001);
      checkOutput("errReady", 9'(mvIf.mv_ready), 9'h001);
      checkOutput("errXs", xs, v.expXs);
      checkOutput("errOs", os, v.expOs);
      @(posedge clk); #1;
      checkOutput("errCleared", 9'(mvIf.mv_err), 9'h000);
    end else begin
      checkOutput("acceptXs", xs, v.expXs);
      checkOutput("acceptNoErr", 9'(mvIf.mv_err), 9'h000);
      @(posedge clk); #1;
      if (!v.expCpu) begin
        checkOutput("endStatus", 9'(status), 9'(v.expStatus));
        checkOutput("endReady", 9'(mvIf.mv_ready), 9'h000);
        checkOutput("endOs", os, v.expOs);
        @(posedge clk); #1;
        checkOutput("endNoCpu", 9'(cpuValid), 9'h000);
      end else begin
        @(posedge clk); #1;
        checkOutput("cpuValid", 9'(cpuValid), 9'h001);
        checkOutput("cpuPos", 9'(cpuPos), 9'(v.expCpuPos));
        checkOutput("cpuOs", os, v.expOs);
        @(posedge clk); #1;
        expReady = (v.expStatus == 2'b00);
        checkOutput("cpuPulseEnd", 9'(cpuValid), 9'h000);
        checkOutput("afterCpuStatus", 9'(status), 9'(v.expStatus));
        checkOutput("afterCpuReady", 9'(mvIf.mv_ready), 9'(expReady));
      end
    end
  endtask

  initial begin
    // newGame, pos, expErr, expCpu, expCpuPos, expStatus, expXs, expOs
    vecs[0]  = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 2'b00, 9'h001, 9'h010};
    vecs[1]  = '{1'b0, 4'd1, 1'b0, 1'b1, 4'd2, 2'b00, 9'h003, 9'h014};
    vecs[2]  = '{1'b0, 4'd6, 1'b0, 1'b1, 4'd3, 2'b00, 9'h043, 9'h01C};
    vecs[3]  = '{1'b0, 4'd5, 1'b0, 1'b1, 4'd8, 2'b00, 9'h063, 9'h11C};
    vecs[4]  = '{1'b0, 4'd7, 1'b0, 1'b0, 4'd0, 2'b11, 9'h0E3, 9'h11C};
    vecs[5]  = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 2'b00, 9'h001, 9'h010};
    vecs[6]  = '{1'b0, 4'd3, 1'b0, 1'b1, 4'd6, 2'b00, 9'h009, 9'h050};
    vecs[7]  = '{1'b0, 4'd2, 1'b0, 1'b1, 4'd1, 2'b00, 9'h00D, 9'h052};
    vecs[8]  = '{1'b0, 4'd8, 1'b0, 1'b1, 4'd7, 2'b10, 9'h10D, 9'h0D2};
    vecs[9]  = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 2'b00, 9'h001, 9'h010};
    vecs[10] = '{1'b0, 4'd4, 1'b1, 1'b0, 4'd0, 2'b00, 9'h001, 9'h010};
    vecs[11] = '{1'b0, 4'd9, 1'b1, 1'b0, 4'd0, 2'b00, 9'h001, 9'h010};
    vecs[12] = '{1'b0, 4'd1, 1'b0, 1'b1, 4'd2, 2'b00, 9'h003, 9'h014};
    vecs[13] = '{1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 2'b00, 9'h001, 9'h010};
    vecs[14] = '{1'b0, 4'd8, 1'b0, 1'b1, 4'd2, 2'b00, 9'h101, 9'h014};
    vecs[15] = '{1'b0, 4'd6, 1'b0, 1'b1, 4'd3, 2'b00, 9'h141, 9'h01C};
    vecs[16] = '{1'b0, 4'd7, 1'b0, 1'b0, 4'd0, 2'b01, 9'h1C1, 9'h01C};

    rst_n         = 1'b0;
    newGame       = 1'b0;
    newGame2      = 1'b0;
    mvIf.mv_valid = 1'b0;
    mvIf.mv_pos   = 4'd0;
    mvIf2.mv_valid = 1'b0;
    mvIf2.mv_pos   = 4'd0;

    #12;
    checkOutput("rstXs", xs, 9'h000);
    checkOutput("rstOs", os, 9'h000);
    checkOutput("rstStatus", 9'(status), 9'h000);
    checkOutput("rstCpuPos", 9'(cpuPos), 9'h000);
    checkOutput("rstCpuValid", 9'(cpuValid), 9'h000);
    checkOutput("rstErr", 9'(mvIf.mv_err), 9'h000);
    checkOutput("rstReady", 9'(mvIf.mv_ready), 9'h000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("startReady", 9'(mvIf.mv_ready), 9'h001);
    checkOutput("cpuFirstNotReady", 9'(mvIf2.mv_ready), 9'h000);
    @(posedge clk); #1;
    checkOutput("cpuFirstValid", 9'(cpuValid2), 9'h001);
    checkOutput("cpuFirstPos", 9'(cpuPos2), 9'h004);
    checkOutput("cpuFirstOs", os2, 9'h010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("cpuFirstReady", 9'(mvIf2.mv_ready), 9'h001);

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
    end

    // Game over after the X win: offered moves are ignored.
    mvIf.mv_valid = 1'b1;
    mvIf.mv_pos   = 4'd1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    mvIf.mv_valid = 1'b0;
    checkOutput("overXs", xs, 9'h1C1);
    checkOutput("overErr", 9'(mvIf.mv_err), 9'h000);
    checkOutput("overStatus", 9'(status), 9'h001);

    // Restart while the X move is being checked.
    startNewGame();
    mvIf.mv_valid = 1'b1;
    mvIf.mv_pos   = 4'd0;
    @(posedge clk); #1;
    mvIf.mv_valid = 1'b0;
    checkOutput("ckxXsPlaced", xs, 9'h001);
    newGame = 1'b1;
    @(posedge clk); #1;
    newGame = 1'b0;
    checkOutput("ckxXs", xs, 9'h000);
    checkOutput("ckxReady", 9'(mvIf.mv_ready), 9'h001);
    @(posedge clk); #1;
    checkOutput("ckxNoCpu", 9'(cpuValid), 9'h000);
    checkOutput("ckxOs", os, 9'h000);

    // Restart coincident with an accepted move drops the move.
    mvIf.mv_valid = 1'b1;
    mvIf.mv_pos   = 4'd2;
    newGame       = 1'b1;
    @(posedge clk); #1;
    mvIf.mv_valid = 1'b0;
    newGame       = 1'b0;
    checkOutput("coXs", xs, 9'h000);
    checkOutput("coErr", 9'(mvIf.mv_err), 9'h000);
    checkOutput("coReady", 9'(mvIf.mv_ready), 9'h001);

    // Asynchronous reset while the computer is choosing.
    mvIf.mv_valid = 1'b1;
    mvIf.mv_pos   = 4'd0;
    @(posedge clk); #1;
    mvIf.mv_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("preRstCpuPos", 9'(cpuPos), 9'h003);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstXs", xs, 9'h000);
    checkOutput("midRstOs", os, 9'h000);
    checkOutput("midRstStatus", 9'(status), 9'h000);
    checkOutput("midRstCpuPos", 9'(cpuPos), 9'h000);
    checkOutput("midRstReady", 9'(mvIf.mv_ready), 9'h000);
    checkOutput("midRstCpuValid", 9'(cpuValid), 9'h000);
    checkOutput("midRstOs2", os2, 9'h000);
    @(posedge clk); #1;
    checkOutput("heldRstOs", os, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRstReady", 9'(mvIf.mv_ready), 9'h001);
    @(posedge clk); #1;
    checkOutput("postRstNoCpu", 9'(cpuValid), 9'h000);
    checkOutput("postRstOs", os, 9'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/ttt_cpu_player.md
# ttt_cpu_player

Sequential tic-tac-toe game engine that owns the board registers and plays the computer side. It accepts human (X) moves over a valid/ready handshake, places them, and checks for end of game. It then chooses and places the computer (O) move using the existing two-in-a-row detector (win, then block, then positional preference). It sits between the user-input front end and the board display and status logic.

## Interface
- `CPU_FIRST`, default 0: 1 = computer places the first piece after reset or `new_game`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `new_game`  in  1  synchronous clear-and-restart, one-cycle pulse.
- `mv_valid`  in  1  human move offered.
- `mv_pos`  in  4  human square index 0..8 (row-major, bit i of board).
- `mv_ready`  out  1  engine can accept a human move.
- `mv_err`  out  1  one-cycle pulse: accepted move was illegal and was discarded.
- `xs`  out  9  X occupancy.
- `os`  out  9  O occupancy.
- `cpu_valid`  out  1  one-cycle pulse: `cpu_pos` is the O piece just placed.
- `cpu_pos`  out  4  last computer square.
- `status`  out  2  00 playing, 01 X won, 10 O won, 11 draw.

## Operation
- Reset (async) gives `xs`=0, `os`=0, `status`=00, `cpu_pos`=0, and `cpu_valid`, `mv_err`, `mv_ready`=0. On the first edge after reset deassertion, the engine behaves as if `new_game` were pulsed.
- `new_game` has priority over everything in any state. It clears the boards and `status`, then enters CPU_MOVE if `CPU_FIRST`, else WAIT_HUMAN.
- States:
  - WAIT_HUMAN: `mv_ready`=1.
  - On `mv_valid && mv_ready`:
    - If `mv_pos`>8 or the square is occupied (`xs|os`), pulse `mv_err` next cycle and stay in WAIT_HUMAN with the board unchanged.
    - Otherwise set `xs[mv_pos]` and go to CHECK_X.
  - CHECK_X:
    - X three-in-line gives `status`=01 and GAME_OVER.
    - Otherwise, `xs|os`=9'h1FF gives `status`=11 and GAME_OVER.
    - Otherwise go to CPU_MOVE.
  - CPU_MOVE: pick a square, set `os[pick]` and `cpu_pos`, pulse `cpu_valid`, go to CHECK_O.
  - CHECK_O:
    - O three-in-line gives 10 and GAME_OVER.
    - Otherwise, full board gives 11 and GAME_OVER.
    - Otherwise go to WAIT_HUMAN.
  - GAME_OVER: holds boards and status, `mv_ready`=0; left only via `new_game`.
- Computer pick priority, taking the lowest set index within the first non-empty mask:
  1. Win: TwoInArray(`os`,`xs`).
  2. Block: TwoInArray(`xs`,`os`).
  3. Centre: 4 if empty.
  4. Corners: 0, 2, 6, 8.
  5. Sides: 1, 3, 5, 7.
  - CPU_MOVE is only entered with at least one empty square.
- Win masks and the full-board check are combinational on registered boards.
- `xs & os` is 0 at all times.

## Timing
- Human move accepted at edge t:
  - `xs` updated at t+1 (CHECK_X).
  - `os`, `cpu_pos` and `cpu_valid` at t+2.
  - `status` final or `mv_ready`=1 at t+3.
- X win or draw: `status` set at t+2, no `cpu_valid`.
- Illegal move: `mv_err`=1 at t+1 only, `mv_ready` stays 1, and a new move can be accepted at t+1.
- `mv_valid` while `mv_ready`=0 is ignored (not queued).
- `new_game` coincident with an accepted move: `new_game` wins and the move is dropped.
- `cpu_valid` and `mv_err` are never high in the same cycle.

## Structure
- Package `ttt_pkg`:
  - State enum: WAIT_HUMAN, CHECK_X, CPU_MOVE, CHECK_O, GAME_OVER.
  - Status encoding constants.
  - `WIN_LINES` (8×9-bit masks).
  - Preference masks CENTER=9'h010, CORNERS=9'h145, SIDES=9'h0AA.
  - Functions `three_in_line(board)` and `lowest_bit(mask)` returning a 4-bit index.
- Sub-modules: two instances of the existing TwoInArray; no new sub-module.

## Test plan
- Draw sequence, CPU_FIRST=0:
  - Human moves: H0, H1, H6, H5, H7.
  - Computer replies, in order: 4 (centre), 2 (block), 3 (block), 8 (corner).
  - After H7: `status`=11 at t+2, with no `cpu_valid` after H7.
- Win over block: H0→4, H3→6, H2→1, H8→CPU picks 7 (win beats block at 5), `status`=10.
- Human win and lowest-index tie-break: H0→4, H8→2, H6→3 (block mask {3,7}), H7→`status`=01, `mv_ready`=0, `os` unchanged.
- Illegal moves:
  - After H0/C4, `mv_pos`=4 gives `mv_err` pulse.
  - `mv_pos`=9 gives `mv_err` pulse.
  - In both cases `xs`=9'h001, `os`=9'h010 are unchanged and the next legal move is accepted.
- Reset and new_game mid-move:
  - `rst_n` low in CPU_MOVE clears all outputs immediately.
  - `new_game` in CHECK_X leaves the board empty and `mv_ready`=1 next cycle.
  - With CPU_FIRST=1, the computer places 4 at first move.
